cache_writeback: RTL and testbench
==================================

CACHE_WRITEBACK -- requirements
Module: cache_writeback

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 8, number of direct-mapped lines; power of two, 2..64.
REQ-002 SHALL derive INDEX_W = log2(NUM_BLOCKS) and TAG_W = 28 - INDEX_W as localparams.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 proc_reset  input  1  asynchronous, active-high reset.
REQ-005 proc_read, proc_write  input  1 each  processor access request.
REQ-006 proc_addr  input  30  word address: tag [29:INDEX_W+2], index [INDEX_W+1:2], word offset [1:0].
REQ-007 proc_wdata  input  32  store data.
REQ-008 proc_stall  output  1  high while the current request is not complete.
REQ-009 proc_rdata  output  32  load data, valid when proc_read is high and proc_stall is low.
REQ-010 mem_read, mem_write  output  1 each  registered memory requests.
REQ-011 mem_addr  output  28  line address.
REQ-012 mem_wdata  output  128  line write-back data.
REQ-013 mem_rdata  input  128  line fill data.
REQ-014 mem_ready  input  1  one-cycle completion pulse from memory.

Function
REQ-015 SHALL store, per line, valid, dirty, TAG_W-bit tag and 4x32-bit data; word k occupies data[32k+31:32k].
REQ-016 SHALL implement states IDLE, WRITEBACK and ALLOCATE.
REQ-017 In IDLE with a request, SHALL signal a hit when the line is valid and the tags match.
REQ-018 On a hit, SHALL drive proc_stall low combinationally in the same cycle.
REQ-019 A read hit SHALL drive proc_rdata with the addressed word.
REQ-020 A write hit SHALL update the addressed word at the next edge and set dirty.
REQ-021 On a miss to an invalid or clean line, SHALL hold proc_stall high and enter ALLOCATE with mem_read=1 and mem_addr=proc_addr[29:2].
REQ-022 On a miss to a valid dirty line, SHALL enter WRITEBACK with mem_write=1, mem_addr={stored tag, index} and mem_wdata=stored data.
REQ-023 In WRITEBACK, on mem_ready SHALL set mem_write=0, mem_read=1, mem_addr=proc_addr[29:2], and enter ALLOCATE.
REQ-024 In ALLOCATE, on mem_ready SHALL set mem_read=0 and write the line with valid=1, the new tag and mem_rdata, then return to IDLE.
REQ-025 For a write miss, the fill in REQ-024 SHALL merge proc_wdata into the addressed word and set dirty=1; for a read miss, dirty SHALL be 0.
REQ-026 After REQ-024, the request SHALL hit in IDLE on the next cycle; clean-miss latency = memory latency + 1 cycle.
REQ-027 mem_read and mem_write SHALL never be high together, and SHALL hold stable until mem_ready.
REQ-028 proc_stall SHALL be high every cycle outside IDLE.
REQ-029 proc_read and proc_write asserted together SHALL be treated as a write.
REQ-030 The processor holds proc_addr, proc_wdata and request lines stable while proc_stall is high.
REQ-031 With no request in IDLE, SHALL hold proc_stall=0, issue no memory request and make no state change.

Reset
REQ-032 proc_reset high SHALL immediately clear all valid, dirty, tag and data bits, and force state=IDLE, mem_read=0, mem_write=0, mem_addr=0.
REQ-033 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transfer; dirty data is lost.
REQ-034 During reset, outputs SHALL be proc_stall=0, proc_rdata=0 and mem_wdata=0.

Configuration
REQ-035 With CACHE_PERF_CNT_EN defined, SHALL add outputs hit_count[31:0] and miss_count[31:0].
REQ-036 hit_count SHALL increment once per request completing without a miss.
REQ-037 miss_count SHALL increment once per miss at IDLE exit.
REQ-038 Both counters SHALL wrap at 2^32 and reset to 0.
REQ-039 Without CACHE_PERF_CNT_EN, the counters and ports SHALL be absent and behaviour otherwise identical.

Verification (NUM_BLOCKS=8)
REQ-040 After reset, read 0x04 -> mem_read=1, mem_addr=0x0000001; return line word0=0x11111111 -> one cycle after mem_ready, proc_stall=0 and proc_rdata=0x11111111.
REQ-041 Repeat read 0x04 -> proc_stall=0 in the same cycle, with no memory request.
REQ-042 Write 0x05 with 0xDEADBEEF -> hit, no stall, line 1 dirty, no mem_write.
REQ-043 Then read 0x24 -> mem_write=1 with mem_addr=0x0000001 and mem_wdata[63:32]=0xDEADBEEF; after mem_ready, mem_read=1 with mem_addr=0x0000009.
REQ-044 Assert proc_reset during the REQ-043 WRITEBACK -> mem_write=0 at once; a later read 0x05 misses with mem_read=1.
REQ-045 With CACHE_PERF_CNT_EN, after REQ-040 to REQ-042 -> hit_count=2 and miss_count=1.

Source files
------------

// File: rtl/cache_writeback.sv
// Direct-mapped write-back, write-allocate cache with a 4-word line and a single memory port.
// Define CACHE_PERF_CNT_EN to add the hit_count / miss_count outputs.
module cache_writeback #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int INDEX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W   = 28 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t state_q, state_d;

    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];
    logic [127:0]          data_d [NUM_BLOCKS];

    logic         mem_read_q, mem_read_d;
    logic         mem_write_q, mem_write_d;
    logic [27:0]  mem_addr_q, mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [1:0]         req_word;
    logic               req;
    logic               hit;
    logic               idle_hit;
    logic               idle_miss;
    logic [127:0]       line;
    logic [127:0]       fill;

    function automatic logic [127:0] put_word(
        input logic [127:0] l,
        input logic [1:0]   w,
        input logic [31:0]  d
    );
        logic [127:0] r;
        r = l;
        r[{w, 5'b0} +: 32] = d;
        return r;
    endfunction

    assign req_tag  = proc_addr[29 -: TAG_W];
    assign req_idx  = proc_addr[INDEX_W+1:2];
    assign req_word = proc_addr[1:0];
    assign req      = proc_read | proc_write;
    assign line     = data_q[req_idx];
    assign hit      = req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign idle_hit  = (state_q == IDLE) && hit;
    assign idle_miss = (state_q == IDLE) && req && !hit;

    // A write miss merges the store into the incoming line so it lands dirty.
    always_comb begin
        fill = mem_rdata;
        if (proc_write) begin
            fill = put_word(mem_rdata, req_word, proc_wdata);
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    if (proc_write) begin
                        data_d[req_idx]  = put_word(line, req_word, proc_wdata);
                        dirty_d[req_idx] = 1'b1;
                    end
                end else if (req) begin
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[req_idx], req_idx};
                        mem_wdata_d = line;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = proc_addr[29:2];
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[29:2];
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_d          = IDLE;
                    mem_read_d       = 1'b0;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = proc_write;
                    tag_d[req_idx]   = req_tag;
                    data_d[req_idx]  = fill;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign proc_stall = !proc_reset && ((state_q != IDLE) || (req && !hit));
    assign proc_rdata = (!proc_reset && idle_hit) ? line[{req_word, 5'b0} +: 32] : '0;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        post_fill_q, post_fill_d;

    // The hit that completes a refilled request belongs to its miss.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        post_fill_d = (state_q == ALLOCATE) && mem_ready;
        if (idle_hit && !post_fill_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (idle_miss) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            post_fill_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            post_fill_q <= post_fill_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_writeback.sv
// Scoreboard bench for cache_writeback: processor-view word memory as reference,
// a randomized-latency line memory, and a decoupled completion monitor.
module tb_cache_writeback;

    localparam int NB = 8;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    cache_writeback #(.NUM_BLOCKS(NB)) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .proc_read (proc_read),
        .proc_write(proc_write),
        .proc_addr (proc_addr),
        .proc_wdata(proc_wdata),
        .proc_stall(proc_stall),
        .proc_rdata(proc_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_rd;
        bit          hit;
        logic [31:0] data;
        int          icyc;
    } exp_t;

    exp_t sb[$];

    logic [127:0] mem_lines [logic [27:0]];
    logic [31:0]  ref_wr [logic [29:0]];

    bit          m_valid [NB];
    bit          m_dirty [NB];
    logic [24:0] m_tag   [NB];

    int exp_wb   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    int           mem_reqs  = 0;
    int           wb_seen   = 0;
    int           ready_cyc = -10;
    logic [27:0]  last_rd_addr = '0;
    logic [27:0]  last_wr_addr = '0;
    logic [127:0] last_wb_data = '0;
    bit           hold_mem  = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_w(input logic [27:0] a, input int k);
        return 32'h9E3779B9 * ({2'b0, a, 2'b0} + 32'(k) + 32'd1);
    endfunction

    function automatic logic [127:0] mline(input logic [27:0] a);
        if (mem_lines.exists(a)) return mem_lines[a];
        return {init_w(a, 3), init_w(a, 2), init_w(a, 1), init_w(a, 0)};
    endfunction

    function automatic logic [31:0] exp_word(input logic [29:0] a);
        logic [127:0] l;
        if (ref_wr.exists(a)) return ref_wr[a];
        l = mline(a[29:2]);
        return l[int'(a[1:0]) * 32 +: 32];
    endfunction

    function automatic logic [127:0] ref_line(input logic [27:0] a);
        return {exp_word({a, 2'd3}), exp_word({a, 2'd2}),
                exp_word({a, 2'd1}), exp_word({a, 2'd0})};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        ref_wr.delete();
        exp_hits = 0;
        exp_miss = 0;
    endfunction

    // Line memory: one transfer at a time, random latency, aborts on reset.
    initial begin
        bit           wr;
        bit           abort;
        logic [27:0]  a;
        logic [127:0] wdat;
        int           lat;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!proc_reset && (mem_read || mem_write)) begin
                wr    = mem_write;
                a     = mem_addr;
                wdat  = mem_wdata;
                lat   = $urandom_range(1, 4);
                abort = 1'b0;
                mem_reqs++;
                chk("mem_excl", 128'(mem_read & mem_write), 128'd0);
                if (wr) begin
                    last_wr_addr = a;
                    last_wb_data = wdat;
                    chk("wb_data", wdat, ref_line(a));
                end else begin
                    last_rd_addr = a;
                end
                while (lat > 0 || hold_mem) begin
                    @(negedge clk);
                    if (proc_reset) begin
                        abort = 1'b1;
                        break;
                    end
                    chk("mem_hold", {mem_write, mem_read, mem_addr}, {wr, !wr, a});
                    lat--;
                end
                @(posedge clk);
                #1;
                if (!abort && !proc_reset) begin
                    mem_ready = 1'b1;
                    ready_cyc = cyc;
                    if (wr) begin
                        mem_lines[a] = wdat;
                        wb_seen++;
                    end else begin
                        mem_rdata = mline(a);
                    end
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b0;
                end
            end
        end
    end

    // Completion monitor: one scoreboard entry per request that drops stall.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!proc_reset && (proc_read || proc_write) && !proc_stall) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: unexpected completion addr %0h", proc_addr);
                end else begin
                    e = sb.pop_front();
                    chk("hit", 128'(cyc == e.icyc), 128'(e.hit));
                    if (e.is_rd) chk("rdata", proc_rdata, e.data);
                    if (!e.hit) chk("miss_lat", 128'(cyc), 128'(ready_cyc + 1));
                end
            end
        end
    end

    task automatic issue(input logic [29:0] a, input int kind, input logic [31:0] wd);
        exp_t e;
        int   idx;
        bit   h;
        bit   wr;
        int   t;
        idx = int'(a[4:2]);
        wr  = (kind != 0);
        h   = m_valid[idx] && (m_tag[idx] == a[29:5]);
        @(posedge clk);
        #1;
        proc_read  = (kind != 1);
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        e.is_rd = !wr;
        e.hit   = h;
        e.data  = exp_word(a);
        e.icyc  = cyc;
        sb.push_back(e);
        if (h) exp_hits++;
        else begin
            exp_miss++;
            if (m_valid[idx] && m_dirty[idx]) exp_wb++;
        end
        m_dirty[idx] = wr ? 1'b1 : (h ? m_dirty[idx] : 1'b0);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[29:5];
        if (wr) ref_wr[a] = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (proc_stall && t < 100);
        if (proc_stall) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: request %0h still stalled", a);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        int          n0;
        int          kind;
        logic [24:0] tg;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        model_reset();
        mem_lines[28'd1] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 128'(proc_stall), 128'd0);
        chk("rst_rdata", 128'(proc_rdata), 128'd0);
        chk("rst_mem_rw", 128'({mem_read, mem_write}), 128'd0);
        chk("rst_mem_addr", 128'(mem_addr), 128'd0);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        @(posedge clk);
        #1;
        proc_reset = 1'b0;

        issue(30'h04, 0, 32'h0);
        chk("fill_addr", 128'(last_rd_addr), 128'h1);
        chk("fill_rdata", 128'(proc_rdata), 128'h11111111);
        n0 = mem_reqs;
        issue(30'h04, 0, 32'h0);
        chk("hit_no_mem", 128'(mem_reqs), 128'(n0));
        issue(30'h05, 1, 32'hDEADBEEF);
        chk("whit_no_mem", 128'(mem_reqs), 128'(n0));
`ifdef CACHE_PERF_CNT_EN
        chk("hit_count_dir", 128'(hit_count), 128'd2);
        chk("miss_count_dir", 128'(miss_count), 128'd1);
`endif
        issue(30'h24, 0, 32'h0);
        chk("wb_addr", 128'(last_wr_addr), 128'h1);
        chk("wb_word1", 128'(last_wb_data[63:32]), 128'hDEADBEEF);
        chk("realloc_addr", 128'(last_rd_addr), 128'h9);

        issue(30'h25, 1, 32'hCAFEF00D);
        hold_mem = 1'b1;
        @(posedge clk);
        #1;
        proc_write = 1'b0;
        proc_read  = 1'b1;
        proc_addr  = 30'h05;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("wb_pending", 128'({mem_write, mem_read}), 128'b10);
        chk("wb_pending_addr", 128'(mem_addr), 128'h9);
        @(posedge clk);
        #1;
        proc_reset = 1'b1;
        #1;
        chk("abort_mem_rw", 128'({mem_read, mem_write}), 128'd0);
        chk("abort_stall", 128'(proc_stall), 128'd0);
        chk("abort_wdata", mem_wdata, 128'd0);
        hold_mem = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        n0 = mem_reqs;
        issue(30'h05, 0, 32'h0);
        chk("post_rst_miss", 128'(mem_reqs), 128'(n0 + 1));
        chk("post_rst_addr", 128'(last_rd_addr), 128'h1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            tg   = ($urandom_range(0, 9) == 0) ? 25'($urandom) : 25'($urandom_range(0, 3));
            kind = $urandom_range(0, 2);
            issue({tg, 3'($urandom_range(0, NB - 1)), 2'($urandom_range(0, 3))},
                  kind, $urandom);
        end
        idle(4);
        chk("wb_count", 128'(wb_seen), 128'(exp_wb));
        chk("sb_drained", 128'(sb.size()), 128'd0);
`ifdef CACHE_PERF_CNT_EN
        chk("hit_count", 128'(hit_count), 128'(exp_hits));
        chk("miss_count", 128'(miss_count), 128'(exp_miss));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
